// File: rtl/spi_regbank_periph_if.sv
// SPI pin bundle between a controller and the register-bank peripheral.
// All pins are asynchronous to the peripheral clock.
interface spi_regbank_periph_if;
  logic ncs;
  logic sclk;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output ncs,
    output sclk,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  ncs,
    input  sclk,
    input  copi,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/spi_regbank_periph.sv
// Oversampled SPI slave (modes 0-3) in front of a config register bank.
// Frame is [W/R][addr][data], MSB first, committed on chip-select release.
module spi_regbank_periph #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regbank_periph_if.slave        spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err,
  output logic                       addr_err
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_HDR =
    CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_END =
    CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT =
    CNT_W'(FRAME_LEN + 1);
  localparam logic [ADDR_W:0] NREGS =
    (ADDR_W + 1)'(NUM_REGS);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA
  } state_t;

  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic ncs_q;
  logic sclk_q;
  logic ncs_s;
  logic sclk_s;
  logic copi_s;
  logic ncs_fall;
  logic ncs_rise;
  logic sclk_rise;
  logic sclk_fall;
  logic sample;
  logic launch;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_LEN-1:0] shift_in;
  logic [FRAME_LEN-1:0] shift_nxt;
  logic [DATA_W-1:0]    shift_out;
  logic [DATA_W-1:0]    rd_data;
  logic [DATA_W-1:0]    regs [NUM_REGS];
  logic                 cipo_q;
  logic                 oe_q;

  logic              hdr_wr;
  logic [ADDR_W-1:0] hdr_addr;
  logic              end_wr;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] end_data;
  logic              end_len_ok;
  logic              end_in_rng;
  logic              end_bad_len;
  logic              end_bad_addr;
  logic              end_write;

  // Sync chains reset low so a chip select already low at reset
  // release never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync  <= '0;
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_q     <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_q     <= ncs_s;
      sclk_q    <= sclk_s;
    end
  end

  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_fall  = ncs_q & ~ncs_s;
  assign ncs_rise  = ~ncs_q & ncs_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;
  assign sample    = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign launch    = SAMPLE_RISE ? sclk_fall : sclk_rise;

  assign shift_nxt = {shift_in[FRAME_LEN-2:0], copi_s};
  assign hdr_wr    = shift_nxt[ADDR_W];
  assign hdr_addr  = shift_nxt[ADDR_W-1:0];
  assign end_wr    = shift_in[FRAME_LEN-1];
  assign end_addr  = shift_in[DATA_W +: ADDR_W];
  assign end_data  = shift_in[DATA_W-1:0];

  assign end_len_ok   = (bit_cnt == CNT_END);
  assign end_in_rng   = ({1'b0, end_addr} < NREGS);
  assign end_bad_len  = ~end_len_ok;
  assign end_bad_addr = end_len_ok & ~end_in_rng;
  assign end_write    = end_len_ok & end_in_rng & end_wr;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      cipo_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      if (ncs_fall) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        shift_in <= '0;
      end else if (ncs_rise && state != IDLE) begin
        state  <= IDLE;
        cipo_q <= 1'b0;
        oe_q   <= 1'b0;
        unique case (1'b1)
          end_bad_len:  frame_err <= 1'b1;
          end_bad_addr: addr_err  <= 1'b1;
          end_write: begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (end_addr == ADDR_W'(i)) begin
                regs[i]      <= end_data;
                wr_strobe[i] <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end else if (state != IDLE && !ncs_s) begin
        if (sample) begin
          shift_in <= shift_nxt;
          if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
          if (state == ADDR && bit_cnt == CNT_HDR) begin
            if (hdr_wr) begin
              state <= WDATA;
            end else begin
              state     <= RDATA;
              shift_out <= rd_data;
              oe_q      <= 1'b1;
            end
          end
        end else if (launch && state == RDATA) begin
          cipo_q    <= shift_out[DATA_W-1];
          shift_out <= shift_out << 1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_regbank_periph.sv
// Drives one SPI stream into four peripherals (modes 0..3) at once
// and scores pulses, read-back data and register contents.
module tb_spi_regbank_periph;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NR = 5;
  localparam int FL = 1 + AW + DW;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs = 1'b1;
  logic sclk_base = 1'b0;
  logic copi = 1'b0;

  always #5 clk = ~clk;

  wire [3:0]          cipo_w;
  wire [3:0]          oe_w;
  wire [3:0]          fe_w;
  wire [3:0]          ae_w;
  wire [3:0][NR-1:0]  ws_w;
  wire [3:0][NR*DW-1:0] regs_w;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int POL = m / 2;
    localparam int PHA = m % 2;
    spi_regbank_periph_if bus ();
    assign bus.ncs  = ncs;
    assign bus.sclk = sclk_base ^ 1'(POL);
    assign bus.copi = copi;
    assign cipo_w[m] = bus.cipo;
    assign oe_w[m]   = bus.cipo_oe;
    spi_regbank_periph #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR),
      .CPOL(POL), .CPHA(PHA), .SYNC_STAGES(2)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .spi(bus),
      .regs_flat(regs_w[m]),
      .wr_strobe(ws_w[m]),
      .frame_err(fe_w[m]),
      .addr_err(ae_w[m])
    );
  end

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_ev [4][$];
  logic [7:0] exp_rd [4][$];
  logic [3:0][31:0] cap;
  logic [3:0][31:0] oec;
  logic [DW-1:0] model [NR];

  // Scoreboard: every pulse cycle must match the next expected event.
  logic [6:0] ev_obs;
  logic [6:0] ev_exp;
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      ev_obs = {ws_w[m], fe_w[m], ae_w[m]};
      if (ev_obs != 7'd0) begin
        checks++;
        if (exp_ev[m].size() == 0) begin
          failures++;
          $display("FAIL event_unexpected mode=%0d got=%b want=none",
                   m, ev_obs);
        end else begin
          ev_exp = exp_ev[m].pop_front();
          if (ev_obs !== ev_exp) begin
            failures++;
            $display("FAIL event mode=%0d got=%b want=%b",
                     m, ev_obs, ev_exp);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word(
    input bit wr, input int a, input int d);
    return {16'b0, wr, 7'(a), 8'(d)};
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic hw();
    repeat (H) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      copi = w[k];
      hw();
      for (int m = 0; m < 4; m += 2) begin
        cap[m] = {cap[m][30:0], cipo_w[m]};
        oec[m] = {oec[m][30:0], oe_w[m]};
      end
      sclk_base = 1'b1;
      hw();
      for (int m = 1; m < 4; m += 2) begin
        cap[m] = {cap[m][30:0], cipo_w[m]};
        oec[m] = {oec[m][30:0], oe_w[m]};
      end
      sclk_base = 1'b0;
      hw();
    end
  endtask

  task automatic frame_begin();
    cap = '0;
    oec = '0;
    ncs = 1'b0;
    hw();
  endtask

  task automatic frame_end();
    ncs  = 1'b1;
    copi = 1'b0;
    hw();
    hw();
  endtask

  task automatic xfer(input logic [31:0] w, input int n);
    frame_begin();
    send_bits(w, n);
    frame_end();
  endtask

  task automatic do_write(input int a, input int d);
    for (int m = 0; m < 4; m++) begin
      if (a < NR) exp_ev[m].push_back({NR'(1 << a), 2'b00});
      else exp_ev[m].push_back(7'b0000001);
    end
    if (a < NR) model[a] = 8'(d);
    xfer(word(1'b1, a, d), FL);
  endtask

  task automatic do_read(input int a);
    for (int m = 0; m < 4; m++) begin
      if (a < NR) begin
        exp_rd[m].push_back(model[a]);
      end else begin
        exp_rd[m].push_back(8'h00);
        exp_ev[m].push_back(7'b0000001);
      end
    end
    xfer(word(1'b0, a, 0), FL);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({regs_w[m], ws_w[m], fe_w[m], ae_w[m],
           cipo_w[m], oe_w[m]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs mode=%0d regs=%h oe=%b want=0",
                 m, regs_w[m], oe_w[m]);
      end
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({regs_w[m], cipo_w[m], oe_w[m]} !== '0) begin
        failures++;
        $display("FAIL post_reset mode=%0d regs=%h oe=%b want=0",
                 m, regs_w[m], oe_w[m]);
      end
    end
  endtask

  task automatic test_write();
    do_write(1, 'hA5);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (regs_w[m] !== model_flat()) begin
        failures++;
        $display("FAIL write_regs mode=%0d got=%h want=%h",
                 m, regs_w[m], model_flat());
      end
      checks++;
      if (exp_ev[m].size() != 0) begin
        failures++;
        $display("FAIL write_strobe_missing mode=%0d pending=%0d want=0",
                 m, exp_ev[m].size());
        exp_ev[m].delete();
      end
    end
  endtask

  task automatic test_read(input int a, input int d);
    do_write(a, d);
    do_read(a);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (cap[m][7:0] !== exp_rd[m][0]) begin
        failures++;
        $display("FAIL read_data mode=%0d got=%h want=%h",
                 m, cap[m][7:0], exp_rd[m][0]);
      end
      void'(exp_rd[m].pop_front());
      checks++;
      if (oec[m][15:0] !== 16'h00FF || oe_w[m] !== 1'b0) begin
        failures++;
        $display("FAIL read_oe mode=%0d got=%h/%b want=00ff/0",
                 m, oec[m][15:0], oe_w[m]);
      end
      checks++;
      if (regs_w[m] !== model_flat() || exp_ev[m].size() != 0) begin
        failures++;
        $display("FAIL read_side mode=%0d regs=%h want=%h pend=%0d",
                 m, regs_w[m], model_flat(), exp_ev[m].size());
        exp_ev[m].delete();
      end
    end
  endtask

  task automatic test_frame_len();
    logic [31:0] w;
    int lens [4];
    w = word(1'b1, 3, 'hFF);
    lens = '{FL - 1, FL + 1, FL + 4, 0};
    for (int t = 0; t < 4; t++) begin
      for (int m = 0; m < 4; m++) exp_ev[m].push_back(7'b0000010);
      if (lens[t] < FL) xfer(w >> (FL - lens[t]), lens[t]);
      else xfer((w << (lens[t] - FL)) | 32'h1, lens[t]);
    end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (regs_w[m] !== model_flat() || exp_ev[m].size() != 0) begin
        failures++;
        $display("FAIL frame_len mode=%0d regs=%h want=%h pend=%0d",
                 m, regs_w[m], model_flat(), exp_ev[m].size());
        exp_ev[m].delete();
      end
    end
  endtask

  task automatic test_addr_err();
    do_write(7, 'h99);
    do_read(7);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (cap[m][7:0] !== exp_rd[m][0]) begin
        failures++;
        $display("FAIL addr_err_read mode=%0d got=%h want=%h",
                 m, cap[m][7:0], exp_rd[m][0]);
      end
      void'(exp_rd[m].pop_front());
      checks++;
      if (regs_w[m] !== model_flat() || exp_ev[m].size() != 0) begin
        failures++;
        $display("FAIL addr_err mode=%0d regs=%h want=%h pend=%0d",
                 m, regs_w[m], model_flat(), exp_ev[m].size());
        exp_ev[m].delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < NR; a++) do_write(a, $urandom_range(1, 255));
    for (int a = 0; a < NR; a++) begin
      do_read(a);
      for (int m = 0; m < 4; m++) begin
        checks++;
        if (cap[m][7:0] !== exp_rd[m][0]) begin
          failures++;
          $display("FAIL b2b_read mode=%0d addr=%0d got=%h want=%h",
                   m, a, cap[m][7:0], exp_rd[m][0]);
        end
        void'(exp_rd[m].pop_front());
      end
    end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (regs_w[m] !== model_flat() || exp_ev[m].size() != 0) begin
        failures++;
        $display("FAIL b2b_regs mode=%0d got=%h want=%h pend=%0d",
                 m, regs_w[m], model_flat(), exp_ev[m].size());
        exp_ev[m].delete();
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] w;
    w = word(1'b1, 0, 'hC3);
    frame_begin();
    send_bits(w >> 7, 9);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (regs_w[m] !== '0 || oe_w[m] !== 1'b0) begin
        failures++;
        $display("FAIL midframe_reset mode=%0d regs=%h oe=%b want=0",
                 m, regs_w[m], oe_w[m]);
      end
    end
    rst_n = 1'b1;
    send_bits(w & 32'h7F, 7);
    frame_end();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (regs_w[m] !== '0) begin
        failures++;
        $display("FAIL midframe_tail mode=%0d regs=%h want=0",
                 m, regs_w[m]);
      end
    end
    do_write(0, 'hC3);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (regs_w[m] !== model_flat() || exp_ev[m].size() != 0) begin
        failures++;
        $display("FAIL midframe_next mode=%0d got=%h want=%h pend=%0d",
                 m, regs_w[m], model_flat(), exp_ev[m].size());
        exp_ev[m].delete();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    cap = '0;
    oec = '0;
    test_reset();
    test_write();
    test_read(4, 'h3C);
    test_read(2, 'h5A);
    test_frame_len();
    test_addr_err();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
